// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache: default-width aliases plus the
// address sequencer's state and mode enums.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [8:0]  lc3b_tag;
    typedef logic [2:0]  lc3b_set;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } addrgen_state_t;

    typedef enum logic {
        MISS  = 1'b0,
        FLUSH = 1'b1
    } addrgen_mode_t;

endpackage

// File: rtl/line_addr_compose.sv
// Builds a line beat address {tag, set, beat*BEAT_BYTES}; the offset is
// formed at OFFSET_W bits, which cannot overflow because BEATS*BEAT_BYTES
// equals the line size.
module line_addr_compose #(
    parameter int TAG_W      = 9,
    parameter int SET_W      = 3,
    parameter int OFFSET_W   = 4,
    parameter int BEAT_W     = 1,
    parameter int BEAT_BYTES = 16
) (
    input  logic [TAG_W-1:0]                  tag,
    input  logic [SET_W-1:0]                  set,
    input  logic [BEAT_W-1:0]                 beat,
    output logic [TAG_W+SET_W+OFFSET_W-1:0]   addr
);

    logic [31:0]         offset_wide;
    logic [OFFSET_W-1:0] offset;

    // Scale beat number to byte offset and concatenate the line address
    always_comb begin
        offset_wide = 32'(beat) * 32'(BEAT_BYTES);
        offset      = offset_wide[OFFSET_W-1:0];
        addr        = {tag, set, offset};
    end

    logic unused_offset_hi;
    assign unused_offset_hi = ^offset_wide[31:OFFSET_W];

endmodule

// File: rtl/cache_miss_addrgen.sv
// Miss/flush address sequencer: latches the victim tag and set on a
// request, issues the writeback beats if dirty, then the fill beats for
// a miss, and pulses done. Outputs depend only on registered state.
module cache_miss_addrgen
    import lc3b_types::*;
#(
    parameter int WAYS     = 2,
    parameter int ADDR_W   = 16,
    parameter int SET_W    = 3,
    parameter int OFFSET_W = 4,
    parameter int BEATS    = 1,
    localparam int TAG_W      = ADDR_W - SET_W - OFFSET_W,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int BEAT_BYTES = (2 ** OFFSET_W) / BEATS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_req,
    input  logic [ADDR_W-1:0]       miss_addr,
    input  logic                    flush_req,
    input  logic [SET_W-1:0]        flush_set,
    input  logic [WAY_W-1:0]        victim_way,
    input  logic                    victim_dirty,
    input  logic [WAYS*TAG_W-1:0]   tags,
    input  logic                    pmem_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_W-1:0]       pmem_address,
    output logic [BEAT_W-1:0]       beat_idx,
    output logic                    busy,
    output logic                    done
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    addrgen_state_t     state_q, state_d;
    addrgen_mode_t      mode_q,  mode_d;
    logic [BEAT_W-1:0]  beat_q,  beat_d;
    logic [TAG_W-1:0]   vtag_q,  vtag_d;
    logic [TAG_W-1:0]   mtag_q,  mtag_d;
    logic [SET_W-1:0]   set_q,   set_d;
    logic               dirty_q, dirty_d;

    logic [TAG_W-1:0]   victim_tag;
    logic [TAG_W-1:0]   comp_tag;
    logic [ADDR_W-1:0]  comp_addr;

    // Select the victim way's tag from the flattened tag bus
    always_comb begin
        victim_tag = tags[int'(victim_way)*TAG_W +: TAG_W];
    end

    // Next-state, beat counter and request latching
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        vtag_d  = vtag_q;
        mtag_d  = mtag_q;
        set_d   = set_q;
        dirty_d = dirty_q;

        unique case (state_q)
            IDLE: begin
                // miss_req has priority; a simultaneous flush_req is dropped
                if (miss_req) begin
                    vtag_d  = victim_tag;
                    set_d   = miss_addr[OFFSET_W +: SET_W];
                    mtag_d  = miss_addr[ADDR_W-1 -: TAG_W];
                    dirty_d = victim_dirty;
                    mode_d  = MISS;
                    beat_d  = '0;
                    state_d = victim_dirty ? WB : FILL;
                end else if (flush_req) begin
                    vtag_d  = victim_tag;
                    set_d   = flush_set;
                    dirty_d = victim_dirty;
                    mode_d  = FLUSH;
                    beat_d  = '0;
                    state_d = victim_dirty ? WB : DONE;
                end
            end
            WB: begin
                if (pmem_resp) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = (mode_q == MISS) ? FILL : DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MISS;
            beat_q  <= '0;
            vtag_q  <= '0;
            mtag_q  <= '0;
            set_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            vtag_q  <= vtag_d;
            mtag_q  <= mtag_d;
            set_q   <= set_d;
            dirty_q <= dirty_d;
        end
    end

    // Writeback uses the victim tag, fill uses the missing address's tag
    always_comb begin
        comp_tag = (state_q == WB) ? vtag_q : mtag_q;
    end

    line_addr_compose #(
        .TAG_W      (TAG_W),
        .SET_W      (SET_W),
        .OFFSET_W   (OFFSET_W),
        .BEAT_W     (BEAT_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_compose (
        .tag  (comp_tag),
        .set  (set_q),
        .beat (beat_q),
        .addr (comp_addr)
    );

    // Memory-side outputs decoded from registered state only
    always_comb begin
        pmem_write   = (state_q == WB);
        pmem_read    = (state_q == FILL);
        pmem_address = (pmem_write || pmem_read) ? comp_addr : '0;
        beat_idx     = beat_q;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
    end

    // dirty_q is kept for visibility of the latched request; the line
    // offset bits of miss_addr never reach the memory address
    logic unused_bits;
    assign unused_bits = ^{dirty_q, miss_addr[OFFSET_W-1:0]};

endmodule

// File: tb/tb_cache_miss_addrgen.sv
// Directed bench for cache_miss_addrgen: default build (BEATS=1) plus a
// BEATS=4 build for the multi-beat fill with wait states.
module tb_cache_miss_addrgen;

  logic        clk;
  logic        rst_n;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        flush_req;
  logic [2:0]  flush_set;
  logic        victim_way;
  logic        victim_dirty;
  logic [17:0] tags;
  logic        pmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic        beat_idx;
  logic        busy;
  logic        done;

  logic        miss_req4;
  logic        flush_req4;
  logic        pmem_resp4;
  logic        pmem_read4;
  logic        pmem_write4;
  logic [15:0] pmem_address4;
  logic [1:0]  beat_idx4;
  logic        busy4;
  logic        done4;

  int n_cmp;
  int n_err;
  int done_cnt;
  int rd_cyc;
  int wr_cyc;
  int both_cyc;

  cache_miss_addrgen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .flush_req    (flush_req),
    .flush_set    (flush_set),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .tags         (tags),
    .pmem_resp    (pmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .beat_idx     (beat_idx),
    .busy         (busy),
    .done         (done)
  );

  cache_miss_addrgen #(.BEATS(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_req     (miss_req4),
    .miss_addr    (miss_addr),
    .flush_req    (flush_req4),
    .flush_set    (flush_set),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .tags         (tags),
    .pmem_resp    (pmem_resp4),
    .pmem_read    (pmem_read4),
    .pmem_write   (pmem_write4),
    .pmem_address (pmem_address4),
    .beat_idx     (beat_idx4),
    .busy         (busy4),
    .done         (done4)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // activity monitor for the default build, sampled on the falling edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pmem_read) rd_cyc++;
    if (pmem_write) wr_cyc++;
    if (pmem_read && pmem_write) both_cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    miss_req   = 1'b0;
    flush_req  = 1'b0;
    miss_req4  = 1'b0;
    flush_req4 = 1'b0;
  endtask

  // per-cycle expectations for the BEATS=4 fill with a 2-cycle stall on beat 1
  logic [15:0] exp4_addr [7];
  logic [1:0]  exp4_idx  [7];
  logic        exp4_resp [7];

  initial begin
    int d0, r0, w0;
    n_cmp = 0; n_err = 0;
    done_cnt = 0; rd_cyc = 0; wr_cyc = 0; both_cyc = 0;

    rst_n = 1'b0;
    miss_req = 0; flush_req = 0; miss_req4 = 0; flush_req4 = 0;
    miss_addr = 16'h0; flush_set = 3'd0; victim_way = 1'b0; victim_dirty = 1'b0;
    tags = 18'h0; pmem_resp = 1'b0; pmem_resp4 = 1'b0;

    // reset values
    #12;
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_addr", {16'b0, pmem_address}, 32'h0);
    check_val("rst_rw", {30'b0, pmem_read, pmem_write}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_beat4", {30'b0, beat_idx4}, 32'd0);
    rst_n = 1'b1;
    step();

    // reset mid-writeback: memory stalls, reset drops everything
    miss_addr = 16'h1234; victim_way = 1'b1; victim_dirty = 1'b1;
    tags = {9'h1FF, 9'h000}; miss_req = 1'b1; pmem_resp = 1'b0;
    step();
    idle_inputs();
    check_val("mid_wb_write", {31'b0, pmem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_wb_write", {31'b0, pmem_write}, 32'd0);
    check_val("rst_wb_busy", {31'b0, busy}, 32'd0);
    check_val("rst_wb_addr", {16'b0, pmem_address}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_val("post_rst_busy", {31'b0, busy}, 32'd0);
    step();
    check_val("post_rst_still_idle", {31'b0, busy}, 32'd0);

    // dirty miss with a late second miss_req and input changes mid-sequence
    d0 = done_cnt; r0 = rd_cyc; w0 = wr_cyc;
    miss_addr = 16'h1234; victim_way = 1'b1; victim_dirty = 1'b1;
    tags = {9'h1FF, 9'h000}; miss_req = 1'b1; pmem_resp = 1'b1;
    step();
    idle_inputs();
    tags = 18'h0; victim_way = 1'b0; victim_dirty = 1'b0;
    miss_req = 1'b1; miss_addr = 16'h4000;
    check_val("dm_write", {31'b0, pmem_write}, 32'd1);
    check_val("dm_read_low", {31'b0, pmem_read}, 32'd0);
    check_val("dm_wb_addr", {16'b0, pmem_address}, 32'hFFB0);
    check_val("dm_busy", {31'b0, busy}, 32'd1);
    step();
    miss_req = 1'b0;
    check_val("dm_read", {31'b0, pmem_read}, 32'd1);
    check_val("dm_write_low", {31'b0, pmem_write}, 32'd0);
    check_val("dm_fill_addr", {16'b0, pmem_address}, 32'h1230);
    step();
    check_val("dm_done", {31'b0, done}, 32'd1);
    check_val("dm_done_addr", {16'b0, pmem_address}, 32'h0);
    step();
    pmem_resp = 1'b0;
    check_val("dm_done_gone", {31'b0, done}, 32'd0);
    check_val("dm_idle", {31'b0, busy}, 32'd0);
    step(); step();
    check_val("dm_one_done", done_cnt - d0, 32'd1);
    check_val("dm_wr_cycles", wr_cyc - w0, 32'd1);
    check_val("dm_rd_cycles", rd_cyc - r0, 32'd1);

    // BEATS=4 clean miss with pmem_resp withheld 2 cycles on beat 1
    exp4_addr = '{16'h1230, 16'h1234, 16'h1234, 16'h1234, 16'h1238, 16'h123C, 16'h0000};
    exp4_idx  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    exp4_resp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    miss_addr = 16'h1234; victim_way = 1'b0; victim_dirty = 1'b0;
    tags = {9'h1FF, 9'h0AA}; miss_req4 = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      pmem_resp4 = exp4_resp[i];
      check_val($sformatf("b4_read_%0d", i), {31'b0, pmem_read4}, 32'd1);
      check_val($sformatf("b4_write_%0d", i), {31'b0, pmem_write4}, 32'd0);
      check_val($sformatf("b4_addr_%0d", i), {16'b0, pmem_address4}, {16'b0, exp4_addr[i]});
      check_val($sformatf("b4_idx_%0d", i), {30'b0, beat_idx4}, {30'b0, exp4_idx[i]});
      step();
    end
    pmem_resp4 = 1'b0;
    check_val("b4_done", {31'b0, done4}, 32'd1);
    check_val("b4_done_addr", {16'b0, pmem_address4}, {16'b0, exp4_addr[6]});
    check_val("b4_done_idx", {30'b0, beat_idx4}, {30'b0, exp4_idx[6]});
    step();
    check_val("b4_idle", {31'b0, busy4}, 32'd0);

    // dirty flush: one write to 0x5550, no read
    d0 = done_cnt; r0 = rd_cyc; w0 = wr_cyc;
    flush_set = 3'd5; victim_way = 1'b0; victim_dirty = 1'b1;
    tags = {9'h123, 9'h0AA}; flush_req = 1'b1; pmem_resp = 1'b1;
    step();
    idle_inputs();
    check_val("fl_write", {31'b0, pmem_write}, 32'd1);
    check_val("fl_addr", {16'b0, pmem_address}, 32'h5550);
    step();
    check_val("fl_done", {31'b0, done}, 32'd1);
    step();
    pmem_resp = 1'b0;
    check_val("fl_idle", {31'b0, busy}, 32'd0);
    step();
    check_val("fl_rd_cycles", rd_cyc - r0, 32'd0);
    check_val("fl_wr_cycles", wr_cyc - w0, 32'd1);
    check_val("fl_one_done", done_cnt - d0, 32'd1);

    // clean flush: done on the next cycle, no memory activity
    d0 = done_cnt; r0 = rd_cyc; w0 = wr_cyc;
    victim_dirty = 1'b0; flush_req = 1'b1;
    step();
    idle_inputs();
    check_val("cf_done", {31'b0, done}, 32'd1);
    check_val("cf_rw", {30'b0, pmem_read, pmem_write}, 32'd0);
    step();
    check_val("cf_idle", {31'b0, busy}, 32'd0);
    check_val("cf_rw_cycles", (rd_cyc - r0) + (wr_cyc - w0), 32'd0);
    check_val("cf_one_done", done_cnt - d0, 32'd1);

    // simultaneous miss and flush: miss wins (clean victim, so fill only)
    d0 = done_cnt; r0 = rd_cyc; w0 = wr_cyc;
    miss_addr = 16'h1234; flush_set = 3'd5; victim_way = 1'b0; victim_dirty = 1'b0;
    tags = {9'h1FF, 9'h0AA}; miss_req = 1'b1; flush_req = 1'b1; pmem_resp = 1'b1;
    step();
    idle_inputs();
    check_val("sim_read", {31'b0, pmem_read}, 32'd1);
    check_val("sim_addr", {16'b0, pmem_address}, 32'h1230);
    step();
    check_val("sim_done", {31'b0, done}, 32'd1);
    step();
    pmem_resp = 1'b0;
    step();
    check_val("sim_wr_cycles", wr_cyc - w0, 32'd0);
    check_val("sim_rd_cycles", rd_cyc - r0, 32'd1);
    check_val("sim_one_done", done_cnt - d0, 32'd1);
    check_val("never_both", both_cyc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_miss_addrgen.md
# cache_miss_addrgen

Parametrised physical-memory address sequencer for an N-way set-associative cache. On a miss it computes the victim writeback address from the victim way's stored tag, issues a multi-beat writeback if the line is dirty, then issues a multi-beat line fill from the missing address. It also runs writeback-only flushes. It sits between the cache datapath/tag arrays and the physical-memory port.

## Interface
- WAYS, 2: associativity; power of two, ≥2.
- ADDR_W, 16: address width (lc3b_word).
- SET_W, 3: set index bits.
- OFFSET_W, 4: line byte-offset bits.
- BEATS, 1: pmem transfers per line; power of two, ≤ 2^OFFSET_W.
- Derived values:
  - TAG_W = ADDR_W−SET_W−OFFSET_W.
  - WAY_W = clog2(WAYS).
  - BEAT_W = max(1, clog2(BEATS)).
  - BEAT_BYTES = 2^OFFSET_W / BEATS.
- Ports:
  - clk  in  1  clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - miss_req  in  1  single-cycle pulse to start miss handling.
  - miss_addr  in  ADDR_W  missing CPU address.
  - flush_req  in  1  single-cycle pulse to start a writeback-only flush.
  - flush_set  in  SET_W  set to flush.
  - victim_way  in  WAY_W  way to evict or flush.
  - victim_dirty  in  1  dirty bit of the victim way.
  - tags  in  WAYS·TAG_W  flattened tags of the addressed set; way i occupies bits [i·TAG_W +: TAG_W].
  - pmem_resp  in  1  beat complete.
  - pmem_read  out  1  fill beat request.
  - pmem_write  out  1  writeback beat request.
  - pmem_address  out  ADDR_W  beat address.
  - beat_idx  out  BEAT_W  current beat number.
  - busy  out  1  high in any state except IDLE.
  - done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - Sample requests. If miss_req and flush_req are both high, miss_req wins and flush_req is dropped.
  - On miss_req, latch:
    - vtag = tags[victim_way]
    - set = miss_addr[OFFSET_W +: SET_W]
    - mtag = miss_addr[ADDR_W−1 -: TAG_W]
    - dirty = victim_dirty
    - mode = MISS
  - On flush_req, latch vtag, set = flush_set, dirty, and mode = FLUSH.
  - After latching, go to WB if dirty. Otherwise go to FILL for MISS, or DONE for FLUSH.
- WB:
  - pmem_write = 1.
  - pmem_address = {vtag, set, beat·BEAT_BYTES}.
  - On each pmem_resp, beat increments.
  - On pmem_resp with beat = BEATS−1: beat returns to 0; go to FILL for MISS, or DONE for FLUSH.
- FILL:
  - pmem_read = 1.
  - pmem_address = {mtag, set, beat·BEAT_BYTES}.
  - On pmem_resp with beat = BEATS−1: beat returns to 0 and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Requests arriving outside IDLE are ignored, not queued.
- pmem_resp is ignored in IDLE and DONE.
- pmem_read and pmem_write are never high together.
- Offset arithmetic: beat·BEAT_BYTES is formed at OFFSET_W bits and cannot overflow.
- Inputs tags, victim_way and victim_dirty are used only in the request cycle; later changes have no effect.

## Timing
- Reset values (asynchronous): state IDLE, beat 0, all latched registers 0, pmem_read 0, pmem_write 0, pmem_address 0, beat_idx 0, busy 0, done 0.
- A reset asserted mid-transfer aborts immediately. No partial-beat recovery is attempted.
- pmem_read, pmem_write and pmem_address are combinational from registered state only; there is no combinational path from any input to any output.
- In IDLE and DONE, pmem_address is 0.
- Latency, request cycle to done cycle, with zero-wait memory (pmem_resp high on the first cycle of each beat):
  - clean miss: BEATS+1 cycles
  - dirty miss: 2·BEATS+1 cycles
  - clean flush: 1 cycle
  - dirty flush: BEATS+1 cycles
- Each memory wait cycle adds one cycle. The address and request are held stable until pmem_resp.
- A new request may be accepted in the cycle after done.

## Structure
- Shared package (lc3b_types), holding:
  - the state enum addrgen_state_t (IDLE, WB, FILL, DONE)
  - the mode enum addrgen_mode_t (MISS, FLUSH)
  - existing lc3b_word/lc3b_tag/lc3b_set remain the default-width aliases
- One sub-module, line_addr_compose: combinational {tag, set, beat·BEAT_BYTES} concatenation, parameterised on widths. Instantiate it once, with the tag muxed by state.
- FSM, beat counter and latch registers live in the top module.

## Test plan
All scenarios use defaults unless noted, giving TAG_W=9.
- Reset mid-WB:
  - Stimulus: assert rst_n=0 while pmem_write=1.
  - Required: same cycle, pmem_write=0, busy=0 and pmem_address=0; after release, state is IDLE.
- Dirty miss:
  - Stimulus: miss_addr=0x1234, victim_way=1, tags way1=0x1FF, dirty=1, zero-wait memory.
  - Required: write to 0xFFB0, then read 0x1230, then done. Total 3 cycles from request.
- Clean miss, BEATS=4:
  - Stimulus: miss_addr=0x1234, clean victim; pmem_resp withheld 2 cycles on beat 1.
  - Required: reads to 0x1230, 0x1234, 0x1238, 0x123C in order; beat_idx 0→3; address held during the wait.
- Flush:
  - Stimulus: flush_req with flush_set=5, victim_way=0, tags way0=0x0AA, dirty=1.
  - Required: one write to 0x5550, then done. No read is ever issued.
  - Stimulus: the same flush with dirty=0.
  - Required: done on the next cycle, no pmem activity.
- Simultaneous and late requests:
  - Stimulus: miss_req and flush_req in the same IDLE cycle.
  - Required: a MISS sequence only.
  - Stimulus: a second miss_req while busy.
  - Required: ignored; exactly one done pulse.
